// File: rtl/mem_stage_pkg.sv
// Shared types and decode helpers for the pipelined memory stage.
package mem_stage_pkg;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  typedef enum logic [1:0] {OP_PASS, OP_LOAD, OP_STORE} op_t;

  // The GPIO window spans the low GPIO_WIN_W address bits above GPIO_BASE
  localparam int unsigned GPIO_WIN_W = 8;
  localparam int unsigned WORD_LSB   = 2;

  typedef struct packed {
    op_t  op;
    logic gpio_hit;
    logic in_range;
  } dec_t;

  // Store wins over load when both strobes are set
  function automatic op_t op_class(input logic wr, input logic rd);
    if (wr) return OP_STORE;
    if (rd) return OP_LOAD;
    return OP_PASS;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Single-port data RAM, synchronous write and registered read.
// Byte-lane writes exist only when MEM_STAGE_BYTE_EN_EN is defined.
module mem_stage_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
`ifdef MEM_STAGE_BYTE_EN_EN
  input  logic [DATA_W/8-1:0]      be,
`endif
  output logic [DATA_W-1:0]        rdata
);

`ifdef MEM_STAGE_BYTE_EN_EN
  localparam int unsigned NB = DATA_W / 8;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
`ifdef MEM_STAGE_BYTE_EN_EN
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
`else
      mem[idx] <= wdata;
`endif
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory stage with valid/ready handshakes, wait-stated data RAM and a GPIO bank.
// Optional byte enables on stores: define MEM_STAGE_BYTE_EN_EN.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       GPIO_CH   = 4,
  parameter logic [ADDR_W-1:0] GPIO_BASE = ADDR_W'(32'hFFFF_FF00)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mem_wr,
  input  logic               mem_rd,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  alu_result,
`ifdef MEM_STAGE_BYTE_EN_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  final_result,
  output logic [GPIO_CH-1:0] gpio_out,
  output logic [GPIO_CH-1:0] gpio_strobe
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CH_W  = (GPIO_CH > 1) ? $clog2(GPIO_CH) : 1;

  state_t            state, state_nxt;
  dec_t              dec_c;
  logic              acc_c, ram_we_c, ram_re_c, gpio_we_c, byte_ok_c;
  logic [IDX_W-1:0]  ram_idx_c;
  logic [CH_W-1:0]   ch_c;
  logic [DATA_W-1:0] ram_rdata, result_c;
  logic              unused_c;

  assign unused_c = ^addr[WORD_LSB-1:0];

  if (GPIO_CH > 1) begin : g_ch
    assign ch_c = addr[WORD_LSB +: CH_W];
  end else begin : g_ch1
    assign ch_c = '0;
  end

  // Address and operation decode
  always_comb begin
    dec_c.op       = op_class(mem_wr, mem_rd);
    dec_c.gpio_hit = (addr[ADDR_W-1:GPIO_WIN_W] == GPIO_BASE[ADDR_W-1:GPIO_WIN_W]);
    dec_c.in_range = (addr[ADDR_W-1:WORD_LSB+IDX_W] == '0);
  end

  assign ram_idx_c = addr[WORD_LSB +: IDX_W];

`ifdef MEM_STAGE_BYTE_EN_EN
  assign byte_ok_c = be[0];
`else
  assign byte_ok_c = 1'b1;
`endif

  assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign acc_c     = in_valid && in_ready;
  assign ram_we_c  = acc_c && (dec_c.op == OP_STORE) && !dec_c.gpio_hit && dec_c.in_range;
  assign ram_re_c  = acc_c && (dec_c.op == OP_LOAD) && !dec_c.gpio_hit && dec_c.in_range;
  assign gpio_we_c = acc_c && (dec_c.op == OP_STORE) && dec_c.gpio_hit && byte_ok_c;

  // Latency-1 result; out-of-range loads read as zero
  always_comb begin
    result_c = alu_result;
    if (dec_c.op == OP_LOAD) begin
      result_c = dec_c.gpio_hit ? DATA_W'(gpio_out[ch_c]) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ram_re_c) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      final_result <= '0;
      gpio_out     <= '0;
      gpio_strobe  <= '0;
    end else begin
      gpio_strobe <= '0;
      if (state == RD_WAIT) begin
        out_valid    <= 1'b1;
        final_result <= ram_rdata;
      end else if (acc_c) begin
        out_valid <= !ram_re_c;
        if (!ram_re_c) final_result <= result_c;
        if (gpio_we_c) begin
          gpio_out[ch_c]    <= wdata[0];
          gpio_strobe[ch_c] <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  mem_stage_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .idx   (ram_idx_c),
    .wdata (wdata),
`ifdef MEM_STAGE_BYTE_EN_EN
    .be    (be),
`endif
    .rdata (ram_rdata)
  );

endmodule
